// File: rtl/cw_pkg.sv
// rtl/cw_pkg.sv - shared state encoding and payload width for the Latin-square winnower
package cw_pkg;
  localparam int DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } state_e;
endpackage

// File: rtl/ls_row_gen.sv
// rtl/ls_row_gen.sv - builds the secret key row one entry per LOAD cycle
module ls_row_gen
  import cw_pkg::*;
#(
  parameter int lslen    = 16,
  parameter int lslenlog = 4
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               start,
  input  logic                               load_en,
  input  logic [lslenlog-1:0]                key_row,
  input  logic [lslen-1:0][lslenlog-1:0]     first_row,
  output logic [lslen-1:0][lslenlog-1:0]     row,
  output logic                               last
);
  localparam int                  PW    = 2 * lslenlog;
  localparam logic [lslenlog-1:0] J_MAX = lslenlog'(lslen - 1);

  logic [lslenlog-1:0]            j_q, j_d;
  logic [lslenlog-1:0]            key_q, key_d;
  logic [lslen-1:0][lslenlog-1:0] row_q, row_d;
  logic [PW-1:0]                  prod;
  logic [lslenlog-1:0]            entry;

  always_comb begin
    prod  = PW'(key_q) * PW'(first_row[j_q]);
    // Row 0 of the square is the shared first row itself, not the all-zero product.
    entry = (key_q == '0) ? first_row[j_q] : lslenlog'(prod % PW'(lslen));
    j_d   = j_q;
    key_d = key_q;
    row_d = row_q;
    if (start) begin
      j_d   = '0;
      key_d = key_row;
    end else if (load_en) begin
      row_d[j_q] = entry;
      j_d        = (j_q == J_MAX) ? '0 : j_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      j_q   <= '0;
      key_q <= '0;
      row_q <= '0;
    end else begin
      j_q   <= j_d;
      key_q <= key_d;
      row_q <= row_d;
    end
  end

  assign row  = row_q;
  assign last = load_en && !start && (j_q == J_MAX);
endmodule

// File: rtl/ls_winnow.sv
// rtl/ls_winnow.sv - keeps the first tag-authenticated candidate of each position group
module ls_winnow
  import cw_pkg::*;
#(
  parameter int lslen    = 16,
  parameter int lslenlog = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [lslen-1:0][lslenlog-1:0] firstRow,
  input  logic                           key_load,
  input  logic [lslenlog-1:0]            key_row,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [DATA_W-1:0]              in_data,
  input  logic [lslenlog-1:0]            in_tag,
  input  logic                           in_last,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [DATA_W-1:0]              out_data,
  output logic [lslenlog-1:0]            out_pos,
  output logic                           out_miss,
  output logic                           out_dup,
  output logic                           out_blk_end,
  output logic                           key_ok
);
  localparam logic [lslenlog-1:0] P_MAX = lslenlog'(lslen - 1);

  state_e                         state_q, state_d;
  logic [lslenlog-1:0]            p_q, p_d;
  logic                           have_q, have_d;
  logic                           dup_q, dup_d;
  logic [DATA_W-1:0]              wheat_q, wheat_d;
  logic                           out_valid_q, out_valid_d;
  logic [DATA_W-1:0]              out_data_q, out_data_d;
  logic [lslenlog-1:0]            out_pos_q, out_pos_d;
  logic                           out_miss_q, out_miss_d;
  logic                           out_dup_q, out_dup_d;
  logic                           out_blk_end_q, out_blk_end_d;
  logic                           key_ok_q, key_ok_d;

  logic [lslen-1:0][lslenlog-1:0] row;
  logic                           gen_last;
  logic                           fire;
  logic                           wheat;

  ls_row_gen #(.lslen(lslen), .lslenlog(lslenlog)) u_row_gen (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (key_load),
    .load_en   (state_q == LOAD),
    .key_row   (key_row),
    .first_row (firstRow),
    .row       (row),
    .last      (gen_last)
  );

  assign in_ready = (state_q == RUN) && (!out_valid_q || out_ready);
  assign fire     = in_valid && in_ready;
  assign wheat    = (in_tag == row[p_q]);

  always_comb begin
    state_d       = state_q;
    p_d           = p_q;
    have_d        = have_q;
    dup_d         = dup_q;
    wheat_d       = wheat_q;
    out_valid_d   = out_valid_q;
    out_data_d    = out_data_q;
    out_pos_d     = out_pos_q;
    out_miss_d    = out_miss_q;
    out_dup_d     = out_dup_q;
    out_blk_end_d = out_blk_end_q;
    if (key_load) begin
      // Restart from any state: drop the partial group and any pending word.
      state_d     = LOAD;
      p_d         = '0;
      have_d      = 1'b0;
      dup_d       = 1'b0;
      wheat_d     = '0;
      out_valid_d = 1'b0;
    end else begin
      unique case (state_q)
        LOAD: if (gen_last) begin
          state_d = RUN;
          p_d     = '0;
        end
        RUN: begin
          if (out_valid_q && out_ready) out_valid_d = 1'b0;
          if (fire && in_last) begin
            out_valid_d   = 1'b1;
            out_data_d    = have_q ? wheat_q : (wheat ? in_data : '0);
            out_pos_d     = p_q;
            out_miss_d    = !(have_q || wheat);
            out_dup_d     = dup_q || (have_q && wheat);
            out_blk_end_d = (p_q == P_MAX);
            p_d           = (p_q == P_MAX) ? '0 : p_q + 1'b1;
            have_d        = 1'b0;
            dup_d         = 1'b0;
            wheat_d       = '0;
          end else if (fire && wheat) begin
            if (have_q) begin
              dup_d = 1'b1;
            end else begin
              have_d  = 1'b1;
              wheat_d = in_data;
            end
          end
        end
        default: ;
      endcase
    end
    key_ok_d = (state_d == RUN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      p_q           <= '0;
      have_q        <= 1'b0;
      dup_q         <= 1'b0;
      wheat_q       <= '0;
      out_valid_q   <= 1'b0;
      out_data_q    <= '0;
      out_pos_q     <= '0;
      out_miss_q    <= 1'b0;
      out_dup_q     <= 1'b0;
      out_blk_end_q <= 1'b0;
      key_ok_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      p_q           <= p_d;
      have_q        <= have_d;
      dup_q         <= dup_d;
      wheat_q       <= wheat_d;
      out_valid_q   <= out_valid_d;
      out_data_q    <= out_data_d;
      out_pos_q     <= out_pos_d;
      out_miss_q    <= out_miss_d;
      out_dup_q     <= out_dup_d;
      out_blk_end_q <= out_blk_end_d;
      key_ok_q      <= key_ok_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;
  assign out_pos     = out_pos_q;
  assign out_miss    = out_miss_q;
  assign out_dup     = out_dup_q;
  assign out_blk_end = out_blk_end_q;
  assign key_ok      = key_ok_q;
endmodule

// File: tb/tb_ls_winnow.sv
// tb/tb_ls_winnow.sv - directed table-driven bench for ls_winnow
module tb_ls_winnow;
  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic [15:0][3:0] first_row;
  logic             key_load = 1'b0;
  logic [3:0]       key_row = '0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [7:0]       in_data = '0;
  logic [3:0]       in_tag = '0;
  logic             in_last = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [7:0]       out_data;
  logic [3:0]       out_pos;
  logic             out_miss, out_dup, out_blk_end, key_ok;

  int pass_cnt = 0;
  int total_cnt = 0;

  typedef struct {
    logic [3:0] tag;
    logic [7:0] data;
    logic       last;
    logic [7:0] e_data;
    logic [3:0] e_pos;
    logic       e_miss;
    logic       e_dup;
    logic       e_end;
  } beat_t;

  beat_t vec[$];

  ls_winnow dut (
    .clk(clk), .rst_n(rst_n), .firstRow(first_row), .key_load(key_load), .key_row(key_row),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_tag(in_tag), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_pos(out_pos),
    .out_miss(out_miss), .out_dup(out_dup), .out_blk_end(out_blk_end), .key_ok(key_ok)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic beat_t mk(input logic [3:0] tag, input logic [7:0] data, input logic last,
                               input logic [7:0] e_data, input logic [3:0] e_pos,
                               input logic e_miss, input logic e_dup, input logic e_end);
    beat_t b;
    b.tag = tag; b.data = data; b.last = last; b.e_data = e_data; b.e_pos = e_pos;
    b.e_miss = e_miss; b.e_dup = e_dup; b.e_end = e_end;
    return b;
  endfunction

  task automatic check_reset_vals();
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_data", 32'(out_data), 0);
    chk("rst_out_pos", 32'(out_pos), 0);
    chk("rst_out_miss", 32'(out_miss), 0);
    chk("rst_out_dup", 32'(out_dup), 0);
    chk("rst_out_blk_end", 32'(out_blk_end), 0);
    chk("rst_key_ok", 32'(key_ok), 0);
    chk("rst_in_ready", 32'(in_ready), 0);
    chk("rst_row1", 32'(dut.row[1]), 0);
    chk("rst_row5", 32'(dut.row[5]), 0);
  endtask

  task automatic do_key(input logic [3:0] k);
    key_row = k; key_load = 1'b1;
    @(posedge clk); #1;
    key_load = 1'b0;
    chk("kl_out_valid", 32'(out_valid), 0);
    for (int c = 1; c <= 16; c++) begin
      @(posedge clk); #1;
      chk("kl_key_ok", 32'(key_ok), 32'(c == 16));
      chk("kl_in_ready", 32'(in_ready), 32'(c == 16));
    end
  endtask

  task automatic send_beat(input logic [3:0] tag, input logic [7:0] data, input logic last);
    int waits = 0;
    in_valid = 1'b1; in_tag = tag; in_data = data; in_last = last;
    #1;
    while (!in_ready && waits < 50) begin
      @(posedge clk); #1;
      waits++;
    end
    chk("beat_accept", 32'(in_ready), 1);
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic chk_out(input logic [7:0] e_data, input logic [3:0] e_pos,
                         input logic e_miss, input logic e_dup, input logic e_end);
    chk("out_valid", 32'(out_valid), 1);
    chk("out_data", 32'(out_data), 32'(e_data));
    chk("out_pos", 32'(out_pos), 32'(e_pos));
    chk("out_miss", 32'(out_miss), 32'(e_miss));
    chk("out_dup", 32'(out_dup), 32'(e_dup));
    chk("out_blk_end", 32'(out_blk_end), 32'(e_end));
  endtask

  initial begin
    for (int j = 0; j < 16; j++) first_row[j] = 4'(j);

    // Key 3 row: 0,3,6,9,12,15,2,5,8,11,14,1,4,7,10,13
    vec.push_back(mk(4'd0,  8'h01, 1'b1, 8'h01, 4'd0, 1'b0, 1'b0, 1'b0));
    vec.push_back(mk(4'd3,  8'h02, 1'b1, 8'h02, 4'd1, 1'b0, 1'b0, 1'b0));
    vec.push_back(mk(4'd5,  8'h99, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 1'b0));
    vec.push_back(mk(4'd6,  8'h03, 1'b1, 8'h03, 4'd2, 1'b0, 1'b0, 1'b0));
    vec.push_back(mk(4'd9,  8'h04, 1'b1, 8'h04, 4'd3, 1'b0, 1'b0, 1'b0));
    vec.push_back(mk(4'd1,  8'h55, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 1'b0));
    vec.push_back(mk(4'd2,  8'h66, 1'b1, 8'h00, 4'd4, 1'b1, 1'b0, 1'b0));
    vec.push_back(mk(4'd2,  8'hA1, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 1'b0));
    vec.push_back(mk(4'd15, 8'hB2, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 1'b0));
    vec.push_back(mk(4'd7,  8'hC3, 1'b1, 8'hB2, 4'd5, 1'b0, 1'b0, 1'b0));
    vec.push_back(mk(4'd2,  8'h11, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 1'b0));
    vec.push_back(mk(4'd2,  8'h22, 1'b1, 8'h11, 4'd6, 1'b0, 1'b1, 1'b0));
    for (int p = 7; p < 16; p++)
      vec.push_back(mk(4'((3 * p) % 16), 8'(8'h70 + p), 1'b1, 8'(8'h70 + p), 4'(p),
                       1'b0, 1'b0, 1'(p == 15)));
    vec.push_back(mk(4'd0, 8'hE0, 1'b1, 8'hE0, 4'd0, 1'b0, 1'b0, 1'b0));

    #2 rst_n = 1'b0;
    #1 check_reset_vals();
    @(posedge clk); #1;
    rst_n = 1'b1;

    do_key(4'd3);
    chk("row5", 32'(dut.row[5]), 15);
    chk("row6", 32'(dut.row[6]), 2);

    foreach (vec[i]) begin
      send_beat(vec[i].tag, vec[i].data, vec[i].last);
      if (vec[i].last) chk_out(vec[i].e_data, vec[i].e_pos, vec[i].e_miss, vec[i].e_dup, vec[i].e_end);
    end

    // Back-pressure: word at pos 1 held while next group's last beat waits.
    send_beat(4'd3, 8'h5A, 1'b1);
    chk_out(8'h5A, 4'd1, 1'b0, 1'b0, 1'b0);
    out_ready = 1'b0;
    in_valid = 1'b1; in_tag = 4'd6; in_data = 8'h6B; in_last = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #1;
      chk("stall_in_ready", 32'(in_ready), 0);
      chk_out(8'h5A, 4'd1, 1'b0, 1'b0, 1'b0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    #1 chk("unstall_in_ready", 32'(in_ready), 1);
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
    chk_out(8'h6B, 4'd2, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    chk("drain_out_valid", 32'(out_valid), 0);

    // key_load with a stalled word pending clears out_valid.
    out_ready = 1'b0;
    send_beat(4'd9, 8'h33, 1'b1);
    chk_out(8'h33, 4'd3, 1'b0, 1'b0, 1'b0);
    do_key(4'd3);
    out_ready = 1'b1;

    // key_load mid-group discards the partial wheat.
    send_beat(4'd0, 8'h77, 1'b0);
    do_key(4'd3);
    send_beat(4'd0, 8'hAB, 1'b1);
    chk_out(8'hAB, 4'd0, 1'b0, 1'b0, 1'b0);

    // Reset in the middle of LOAD.
    key_load = 1'b1;
    @(posedge clk); #1;
    key_load = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b0;
    #1 check_reset_vals();

    // key_load while reset is held is ignored.
    key_load = 1'b1;
    @(posedge clk); #1;
    key_load = 1'b0;
    rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    chk("rst_kl_key_ok", 32'(key_ok), 0);
    chk("rst_kl_in_ready", 32'(in_ready), 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/ls_winnow.md
LS_WINNOW -- requirements
Module: ls_winnow

Interface
REQ-001 SHALL have parameter lslen, default 16, meaning Latin-square order (symbols per row, positions per block).
REQ-002 SHALL have parameter lslenlog, default 4, meaning log2(lslen), the symbol width.
REQ-003 SHALL have port clk, input, 1, the single clock; all flops SHALL be rising-edge.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port firstRow, input, [lslen-1:0][lslenlog-1:0], the shared first row of the square.
REQ-006 SHALL have port key_load, input, 1, a single-cycle pulse that starts a key load.
REQ-007 SHALL have port key_row, input, lslenlog, the secret row index, sampled with key_load.
REQ-008 SHALL have port in_valid, input, 1, candidate-packet valid.
REQ-009 SHALL have port in_ready, output, 1, candidate-packet ready.
REQ-010 SHALL have port in_data, input, 8, candidate payload.
REQ-011 SHALL have port in_tag, input, lslenlog, candidate authentication tag.
REQ-012 SHALL have port in_last, input, 1, marking the last candidate of the current position group.
REQ-013 SHALL have port out_valid, input/output pair out_valid (output) and out_ready (input), 1 each, for the winnowed-word handshake.
REQ-014 SHALL have outputs out_data (8), out_pos (lslenlog), out_miss (1), out_dup (1) and out_blk_end (1).
REQ-015 SHALL have output key_ok, 1, high while the block is in RUN.

Function
REQ-016 SHALL implement FSM states IDLE, LOAD and RUN.
REQ-017 SHALL make the transitions IDLE->LOAD on key_load, LOAD->RUN after exactly lslen LOAD cycles, and any state->LOAD on key_load (restart).
REQ-018 SHALL, in LOAD, compute one entry per cycle with counter j = 0..lslen-1: row[j] = firstRow[j] when key_row = 0, else (key_row*firstRow[j]) mod lslen, truncated to lslenlog bits.
REQ-019 SHALL define in_ready = (state==RUN) && (!out_valid || out_ready); a transfer SHALL occur only when in_valid && in_ready.
REQ-020 SHALL keep a position counter p, resetting it to 0 on entry to RUN.
REQ-021 SHALL treat an accepted candidate as wheat iff in_tag == row[p], including on the in_last beat.
REQ-022 SHALL latch the payload of the first wheat in a group; later wheat SHALL set the group's dup flag and not overwrite the latched payload.
REQ-023 SHALL, on an accepted in_last, load the output register on the next edge with out_data = latched wheat (0 if none), out_pos = p, out_miss = no wheat seen, out_dup = more than one wheat seen, out_blk_end = (p == lslen-1).
REQ-024 SHALL, on an accepted in_last, clear the group state, increment p, and wrap p from lslen-1 to 0.
REQ-025 SHALL hold out_valid and all out_* stable until out_ready is high; out_valid SHALL clear on the handshake unless a new word loads in the same cycle.
REQ-026 SHALL, on key_load in RUN, abort the current group, clear out_valid and p, and discard the partial group.
REQ-027 SHALL ignore key_load during reset.

Reset
REQ-028 SHALL, on rst_n low, asynchronously set state=IDLE, p=0, j=0, row entries=0, out_valid=0, out_data=0, out_pos=0, out_miss=0, out_dup=0, out_blk_end=0, key_ok=0 and the group flags to 0.
REQ-029 SHALL keep in_ready low in IDLE and LOAD.

Structure
REQ-030 SHALL place the FSM state enum and the payload width constant (8) in shared package cw_pkg.
REQ-031 SHALL implement the key-row generator (LOAD counter plus multiply-mod) as sub-module ls_row_gen, instantiated once.

Verification
REQ-032 SHALL cover: firstRow[j]=j, key_row=3, key_load pulse -> key_ok and in_ready high exactly 16 cycles later; row[5]=15, row[6]=2.
REQ-033 SHALL cover: at p=5, tags {2,15,7} with data {A1,B2,C3}, last on the 3rd -> out_data=B2, out_pos=5, miss=0, dup=0.
REQ-034 SHALL cover: a group with no matching tag -> out_miss=1, out_data=00; two matches (data 11 then 22) -> out_dup=1, out_data=11.
REQ-035 SHALL cover: 16 groups -> out_blk_end=1 only on pos 15, and the next group reports pos 0.
REQ-036 SHALL cover: out_ready held low for 4 cycles with out_valid high -> in_ready low, outputs stable, no loss.
REQ-037 SHALL cover: key_load mid-group in RUN -> out_valid=0, in_ready low for 16 cycles, next word pos=0; rst_n low mid-LOAD -> all reset values immediately.
